prbs7_rx_checker: RTL
=====================

// Module: prbs7_rx_checker
// PURPOSE
// Downstream consumer of the transceiver RX word (gt0_rxdata_i) in the PRBS7 link test.
// Self-synchronises to the incoming PRBS7 stream (x^7+x^6+1, LSB-first), then counts bit errors.
// Bit errors are counted against a free-running local generator.
// Provides lock status and error/word/lock-loss statistics for debug probing on the RX user clock.
// PARAMETERS
// WORDWIDTH    32  data word width; must be >= 8
// LOCK_WORDS   16  consecutive matching words in SEARCH required to declare lock (>=1)
// UNLOCK_WORDS 8   consecutive errored words in LOCKED that drop lock (>=1)
// CNT_WIDTH    32  width of err_count and word_count
// PORTS
// clk          in   1            RX user clock; all logic on rising edge
// reset        in   1            synchronous, active-high
// din          in   WORDWIDTH    received word; din[0] is the earliest bit on the line
// din_valid    in   1            din qualifier; words with din_valid=0 are ignored
// clear        in   1            synchronous clear of err_count, word_count, lock_loss
// locked       out  1            1 while in LOCKED state
// err_valid    out  1            1-cycle pulse: err_bits is valid for a word checked in LOCKED
// err_bits     out  clog2(W)+1   popcount of mismatching bits in the last checked word
// err_count    out  CNT_WIDTH    saturating total of bit errors while locked
// word_count   out  CNT_WIDTH    saturating count of words checked while locked
// lock_loss    out  8            saturating count of LOCKED->SEARCH transitions
// BEHAVIOUR
// Reset: all outputs 0; state=SEARCH; good_cnt=0; bad_cnt=0; have_prev=0; gen_state=0.
// Sequence rule: b[n] = b[n-6] ^ b[n-7].
// pred(s) = next WORDWIDTH bits extended from the 7-bit history s, where s[6] is the most recent bit.
// Compute pred combinationally in a single unrolled loop.
// All state updates occur only on cycles with din_valid=1; with din_valid=0 nothing changes and err_valid=0.
// SEARCH state:
//  - Word 1 after entry: store din[W-1:W-7] as prev; set have_prev=1; no compare.
//  - Following words: match = (din == pred(prev)) && (din != 0).
//    All-zero words never match, so the block must not lock on a dead link.
//    Then set prev = din[W-1:W-7].
//  - match: good_cnt++. mismatch: good_cnt=0.
//  - When good_cnt reaches LOCK_WORDS: go to LOCKED; gen_state = din[W-1:W-7]; bad_cnt=0.
//  - In SEARCH: err_valid=0; err_count and word_count do not advance.
// LOCKED state:
//  - Per valid word: p = pred(gen_state); gen_state <= p[W-1:W-7].
//    gen_state is never reloaded from din, so each line error counts exactly once.
//  - err_bits <= popcount(din ^ p); err_valid <= 1.
//  - err_count += popcount and word_count += 1, both saturating at all-ones.
//  - Errored word (popcount>0): bad_cnt++. Clean word: bad_cnt=0.
//  - When bad_cnt reaches UNLOCK_WORDS: go to SEARCH; lock_loss+1 (saturating at 255).
//    Also good_cnt=0, prev = din[W-1:W-7], have_prev=1.
//    The word that triggers unlock is still counted in err_count and word_count.
// Latency: locked, err_*, word_count and lock_loss update on the clock edge that samples the valid word.
//   They are visible the following cycle (1-cycle registered latency).
// clear: on the same edge, err_count, word_count and lock_loss become 0.
//   clear wins over a simultaneous increment; that word's contribution is discarded.
//   clear does not affect state, locked or err_bits.
// reset mid-operation: immediate return to the reset values above, irrespective of state or clear.
// TESTING
// Error-free PRBS7 from seed 7'h7F, din_valid=1 -> locked=1 one cycle after the 17th word.
//   That is 1 prev-load word + 16 matches; err_count stays 0 and word_count increments once per word.
// Locked, flip din[5] of one word -> err_bits=1 and err_valid=1 for that word.
//   err_count=1 afterwards; next clean word shows err_bits=0; locked stays 1.
// din held at 32'h0 for 100 words after reset -> locked stays 0; all counters remain 0.
// Locked, 8 consecutive words with 1 flipped bit each -> locked=0 after the 8th; lock_loss=1; err_count=8.
//   Then clean PRBS relocks after 16 further matching words.
// din_valid toggling 1/0 on clean PRBS -> lock after 17 valid words; no count advances on invalid cycles.
// Assert clear on the same cycle as an errored word -> err_count=0 next cycle.
//   Assert reset while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/prbs7_rx_checker.sv
// rtl/prbs7_rx_checker.sv - self-synchronising PRBS7 (x^7+x^6+1, LSB-first) receive checker with error statistics
module prbs7_rx_checker #(
   parameter int WORDWIDTH    = 32,
   parameter int LOCK_WORDS   = 16,
   parameter int UNLOCK_WORDS = 8,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WORDWIDTH-1:0]         din,
   input  logic                         din_valid,
   input  logic                         clear,
   output logic                         locked,
   output logic                         err_valid,
   output logic [$clog2(WORDWIDTH):0]   err_bits,
   output logic [CNT_WIDTH-1:0]         err_count,
   output logic [CNT_WIDTH-1:0]         word_count,
   output logic [7:0]                   lock_loss
);

   localparam int EBW = $clog2(WORDWIDTH) + 1;
   localparam int GW  = $clog2(LOCK_WORDS + 1);
   localparam int BW  = $clog2(UNLOCK_WORDS + 1);

   localparam logic [GW-1:0]        G_ONE    = GW'(1);
   localparam logic [GW-1:0]        LOCK_G   = GW'(LOCK_WORDS);
   localparam logic [BW-1:0]        B_ONE    = BW'(1);
   localparam logic [BW-1:0]        UNLOCK_B = BW'(UNLOCK_WORDS);
   localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t               state;
   logic [6:0]           prev;
   logic                 have_prev;
   logic [6:0]           gen_state;
   logic [GW-1:0]        good_cnt;
   logic [BW-1:0]        bad_cnt;

   logic [WORDWIDTH-1:0] pred_prev;
   logic [WORDWIDTH-1:0] pred_gen;
   logic [WORDWIDTH-1:0] diff;
   logic [EBW-1:0]       pop;
   logic                 match;
   logic [GW-1:0]        good_next;
   logic [BW-1:0]        bad_next;
   logic [CNT_WIDTH:0]   err_sum;
   logic [CNT_WIDTH-1:0] err_sat;
   logic [CNT_WIDTH-1:0] word_sat;
   logic [7:0]           loss_sat;

   // Extend the 7-bit history (bit 6 newest) by WORDWIDTH bits using b[n] = b[n-6] ^ b[n-7].
   function automatic logic [WORDWIDTH-1:0] pred(input logic [6:0] s);
      logic [WORDWIDTH+6:0] ext;
      ext        = '0;
      ext[6:0]   = s;
      for (int i = 0; i < WORDWIDTH; i++) begin
         ext[i+7] = ext[i+1] ^ ext[i];
      end
      return ext[WORDWIDTH+6:7];
   endfunction

   always_comb begin
      pred_prev = pred(prev);
      pred_gen  = pred(gen_state);
      diff      = din ^ pred_gen;
      pop       = '0;
      for (int i = 0; i < WORDWIDTH; i++) begin
         pop = pop + EBW'(diff[i]);
      end
      match     = (din == pred_prev) && (din != '0);
      good_next = good_cnt + G_ONE;
      bad_next  = bad_cnt + B_ONE;
      err_sum   = {1'b0, err_count} + (CNT_WIDTH+1)'(pop);
      err_sat   = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
      word_sat  = (&word_count) ? word_count : word_count + C_ONE;
      loss_sat  = (&lock_loss) ? lock_loss : lock_loss + 8'd1;
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SEARCH;
         prev       <= '0;
         have_prev  <= 1'b0;
         gen_state  <= '0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
         err_valid  <= 1'b0;
         err_bits   <= '0;
         err_count  <= '0;
         word_count <= '0;
         lock_loss  <= '0;
      end else begin
         err_valid <= 1'b0;
         if (din_valid) begin
            case (state)
               SEARCH: begin
                  prev      <= din[WORDWIDTH-1 -: 7];
                  have_prev <= 1'b1;
                  if (have_prev) begin
                     if (match) begin
                        good_cnt <= good_next;
                        if (good_next == LOCK_G) begin
                           state     <= LOCKED;
                           gen_state <= din[WORDWIDTH-1 -: 7];
                           bad_cnt   <= '0;
                        end
                     end else begin
                        good_cnt <= '0;
                     end
                  end
               end
               LOCKED: begin
                  // Free-running: gen_state never resyncs to din, so a line error is counted once.
                  gen_state  <= pred_gen[WORDWIDTH-1 -: 7];
                  err_bits   <= pop;
                  err_valid  <= 1'b1;
                  err_count  <= err_sat;
                  word_count <= word_sat;
                  if (pop != '0) begin
                     bad_cnt <= bad_next;
                     if (bad_next == UNLOCK_B) begin
                        state     <= SEARCH;
                        lock_loss <= loss_sat;
                        good_cnt  <= '0;
                        bad_cnt   <= '0;
                        prev      <= din[WORDWIDTH-1 -: 7];
                        have_prev <= 1'b1;
                     end
                  end else begin
                     bad_cnt <= '0;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
         if (clear) begin
            err_count  <= '0;
            word_count <= '0;
            lock_loss  <= '0;
         end
      end
   end

endmodule
